// File: rtl/flash_cache_stats.sv
// Cache hit/miss performance monitor: saturating lifetime counters plus last-window totals,
// read by the core over a select/wstrb/ready register bus.
module flash_cache_stats #(
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned WINDOW_CYC = 1_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        hit_i,
   input  logic        miss_i,
   input  logic        select,
   input  logic [3:0]  wstrb,
   input  logic [4:0]  addr,
   input  logic [31:0] data_i,
   output logic        ready,
   output logic [31:0] data_o
);

   localparam int unsigned       TMR_W    = $clog2(WINDOW_CYC);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(WINDOW_CYC - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   typedef enum logic {S_IDLE, S_DONE} state_t;

   state_t             state;
   logic               enable;
   logic               win_valid;
   logic [CNT_W-1:0]   hits;
   logic [CNT_W-1:0]   misses;
   logic [CNT_W-1:0]   win_hits;
   logic [CNT_W-1:0]   win_misses;
   logic [CNT_W-1:0]   run_hits;
   logic [CNT_W-1:0]   run_misses;
   logic [TMR_W-1:0]   timer;

   logic [2:0]         idx_c;
   logic               access_c;
   logic               ctrl_wr_c;
   logic               clear_c;
   logic [31:0]        rd_data_c;
   logic               unused_c;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
   endfunction

   assign idx_c     = addr[4:2];
   assign access_c  = (state == S_IDLE) && select;
   assign ctrl_wr_c = access_c && (wstrb != 4'd0) && (idx_c == 3'd0);
   assign clear_c   = ctrl_wr_c && data_i[1];
   assign unused_c  = ^{addr[1:0], data_i[31:2]};

   // Register read mux; counters zero-extended to the bus width
   always_comb begin
      rd_data_c = '0;
      case (idx_c)
         3'd0:    rd_data_c = {29'd0, win_valid, 1'b0, enable};
         3'd1:    rd_data_c = 32'(hits);
         3'd2:    rd_data_c = 32'(misses);
         3'd3:    rd_data_c = 32'(win_hits);
         3'd4:    rd_data_c = 32'(win_misses);
         3'd5:    rd_data_c = 32'(WINDOW_CYC);
         default: rd_data_c = '0;
      endcase
   end

   // Bus FSM: access performed on leaving IDLE, ready held for the single DONE cycle
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         ready  <= 1'b0;
         data_o <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               ready <= 1'b0;
               if (select) begin
                  state <= S_DONE;
                  ready <= 1'b1;
                  if (wstrb == 4'd0) data_o <= rd_data_c;
               end
            end
            S_DONE: begin
               ready <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               ready <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Counters and window timer; clear overrides both counting and rollover
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         enable     <= 1'b1;
         win_valid  <= 1'b0;
         hits       <= '0;
         misses     <= '0;
         win_hits   <= '0;
         win_misses <= '0;
         run_hits   <= '0;
         run_misses <= '0;
         timer      <= '0;
      end else begin
         if (ctrl_wr_c) enable <= data_i[0];
         if (clear_c) begin
            win_valid  <= 1'b0;
            hits       <= '0;
            misses     <= '0;
            win_hits   <= '0;
            win_misses <= '0;
            run_hits   <= '0;
            run_misses <= '0;
            timer      <= '0;
         end else if (enable) begin
            hits   <= sat_inc(hits, hit_i);
            misses <= sat_inc(misses, miss_i);
            if (timer == TMR_LAST) begin
               win_hits   <= sat_inc(run_hits, hit_i);
               win_misses <= sat_inc(run_misses, miss_i);
               run_hits   <= '0;
               run_misses <= '0;
               timer      <= '0;
               win_valid  <= 1'b1;
            end else begin
               run_hits   <= sat_inc(run_hits, hit_i);
               run_misses <= sat_inc(run_misses, miss_i);
               timer      <= timer + TMR_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_flash_cache_stats.sv
// Self-checking bench for flash_cache_stats: constant vector table, directed corner sequences,
// and randomized traffic checked against an event-level reference model.
module tb_flash_cache_stats;

   localparam int unsigned CW   = 8;
   localparam int unsigned WIN  = 16;
   localparam int          MAXV = (1 << CW) - 1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        hit_i = 1'b0;
   logic        miss_i = 1'b0;
   logic        select = 1'b0;
   logic [3:0]  wstrb = 4'd0;
   logic [4:0]  addr = 5'd0;
   logic [31:0] data_i = 32'd0;
   logic        ready;
   logic [31:0] data_o;

   int checks = 0;
   int errors = 0;
   bit rnd_on = 1'b0;

   flash_cache_stats #(.CNT_W(CW), .WINDOW_CYC(WIN)) dut (
      .clk(clk), .reset_n(reset_n), .hit_i(hit_i), .miss_i(miss_i),
      .select(select), .wstrb(wstrb), .addr(addr), .data_i(data_i),
      .ready(ready), .data_o(data_o)
   );

   always #5 clk = ~clk;

   // Reference model: event counts per cycle, saturating with min(), window as a cycle count
   int          m_hits, m_misses, m_wh, m_wm, m_rh, m_rm, m_tmr;
   bit          m_en, m_wv, m_wr;
   logic [31:0] m_wd;
   int          s_h, s_m;

   function automatic int sat(input int v);
      return (v > MAXV) ? MAXV : v;
   endfunction

   always @(posedge clk) begin
      if (!reset_n) begin
         m_hits = 0; m_misses = 0; m_wh = 0; m_wm = 0; m_rh = 0; m_rm = 0; m_tmr = 0;
         m_en = 1'b1; m_wv = 1'b0; m_wr = 1'b0;
      end else begin
         s_h = int'(hit_i);
         s_m = int'(miss_i);
         if (m_wr && m_wd[1]) begin
            m_hits = 0; m_misses = 0; m_wh = 0; m_wm = 0; m_rh = 0; m_rm = 0; m_tmr = 0;
            m_wv = 1'b0;
         end else if (m_en) begin
            m_hits   = sat(m_hits + s_h);
            m_misses = sat(m_misses + s_m);
            m_rh     = sat(m_rh + s_h);
            m_rm     = sat(m_rm + s_m);
            if (m_tmr == int'(WIN) - 1) begin
               m_wh = m_rh; m_wm = m_rm; m_rh = 0; m_rm = 0; m_tmr = 0; m_wv = 1'b1;
            end else begin
               m_tmr = m_tmr + 1;
            end
         end
         if (m_wr) m_en = m_wd[0];
         m_wr = 1'b0;
      end
   end

   function automatic logic [31:0] mdl_rd(input logic [2:0] idx);
      case (idx)
         3'd0:    return {29'd0, m_wv, 1'b0, m_en};
         3'd1:    return 32'(m_hits);
         3'd2:    return 32'(m_misses);
         3'd3:    return 32'(m_wh);
         3'd4:    return 32'(m_wm);
         3'd5:    return 32'(WIN);
         default: return 32'd0;
      endcase
   endfunction

   always @(negedge clk) begin
      if (rnd_on) begin
         hit_i  = ($urandom_range(0, 2) == 0);
         miss_i = ($urandom_range(0, 3) == 0);
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, want);
      end
   endtask

   // One bus transfer; exp is the model value at the sampling edge (strobes of that cycle excluded)
   task automatic bus(input logic [3:0] ws, input logic [4:0] a, input logic [31:0] d,
                      input bit hs, output logic [31:0] rd, output logic [31:0] exp);
      bit got;
      @(negedge clk);
      exp    = mdl_rd(a[4:2]);
      select = 1'b1; wstrb = ws; addr = a; data_i = d;
      if (hs) hit_i = 1'b1;
      if (ws != 4'd0 && a[4:2] == 3'd0) begin m_wd = d; m_wr = 1'b1; end
      @(negedge clk);
      if (hs) hit_i = 1'b0;
      got = ready;
      check("ready_latency", 32'(ready), 32'd1);
      for (int i = 0; i < 3 && !got; i++) begin
         @(negedge clk);
         got = ready;
      end
      rd = data_o;
      select = 1'b0; wstrb = 4'd0;
   endtask

   task automatic rd_const(input logic [4:0] a, input string nm, input logic [31:0] want);
      logic [31:0] rd, exp;
      bus(4'd0, a, 32'd0, 1'b0, rd, exp);
      check(nm, rd, want);
      check({nm, "_model"}, rd, exp);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input bit hs);
      logic [31:0] rd, exp;
      bus(4'hF, a, d, hs, rd, exp);
   endtask

   task automatic pulse(input bit h, input bit m, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); hit_i = h; miss_i = m;
         @(negedge clk); hit_i = 1'b0; miss_i = 1'b0;
      end
   endtask

   typedef struct {
      logic [3:0]  ws;
      logic [4:0]  a;
      logic [31:0] d;
      logic [31:0] exp;
      string       nm;
   } vec_t;

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      vec_t        tbl[$];
      logic [31:0] rd, exp;
      bit          seen;

      tbl.push_back('{4'h0, 5'h00, 32'h0,    32'h1,  "rst_ctrl"});
      tbl.push_back('{4'h1, 5'h00, 32'h2,    32'h0,  "wr_ctrl_off"});
      tbl.push_back('{4'h0, 5'h00, 32'h0,    32'h0,  "ctrl_off"});
      tbl.push_back('{4'h0, 5'h04, 32'h0,    32'h0,  "rst_hits"});
      tbl.push_back('{4'h0, 5'h08, 32'h0,    32'h0,  "rst_misses"});
      tbl.push_back('{4'h0, 5'h0C, 32'h0,    32'h0,  "rst_whits"});
      tbl.push_back('{4'h0, 5'h10, 32'h0,    32'h0,  "rst_wmiss"});
      tbl.push_back('{4'h0, 5'h14, 32'h0,    32'd16, "wlen"});
      tbl.push_back('{4'h0, 5'h17, 32'h0,    32'd16, "wlen_lowbits"});
      tbl.push_back('{4'h0, 5'h18, 32'h0,    32'h0,  "idx6"});
      tbl.push_back('{4'h0, 5'h1C, 32'h0,    32'h0,  "idx7"});
      tbl.push_back('{4'h3, 5'h04, 32'hFFFF, 32'h0,  "wr_hits_ro"});
      tbl.push_back('{4'h0, 5'h04, 32'h0,    32'h0,  "hits_after_ro_wr"});
      tbl.push_back('{4'h8, 5'h00, 32'h1,    32'h0,  "wr_ctrl_on"});
      tbl.push_back('{4'h0, 5'h00, 32'h0,    32'h1,  "ctrl_on"});

      repeat (3) @(negedge clk);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_data_o", data_o, 32'd0);
      reset_n = 1'b1;

      foreach (tbl[i]) begin
         bus(tbl[i].ws, tbl[i].a, tbl[i].d, 1'b0, rd, exp);
         if (tbl[i].ws == 4'd0) begin
            check(tbl[i].nm, rd, tbl[i].exp);
            check({tbl[i].nm, "_model"}, rd, exp);
         end
      end

      // Window rollover: 5 hits, 3 misses (one cycle with both) in window 0
      wr(5'h00, 32'h3, 1'b0);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         hit_i  = (i != 1 && i != 4);
         miss_i = (i == 1 || i == 2 || i == 4);
      end
      @(negedge clk); hit_i = 1'b0; miss_i = 1'b0;
      repeat (10) @(negedge clk);
      rd_const(5'h0C, "win_whits", 32'd5);
      rd_const(5'h10, "win_wmiss", 32'd3);
      rd_const(5'h00, "win_ctrl",  32'h5);
      rd_const(5'h04, "win_hits",  32'd5);
      rd_const(5'h08, "win_misses", 32'd3);

      // Saturation at 2^CW-1
      wr(5'h00, 32'h3, 1'b0);
      @(negedge clk); hit_i = 1'b1;
      repeat (300) @(negedge clk);
      hit_i = 1'b0;
      rd_const(5'h04, "sat_hits", 32'd255);
      pulse(1'b1, 1'b0, 1);
      rd_const(5'h04, "sat_hits_hold", 32'd255);

      // Disable gating, then clear colliding with a hit
      wr(5'h00, 32'h3, 1'b0);
      pulse(1'b1, 1'b0, 4);
      wr(5'h00, 32'h0, 1'b0);
      pulse(1'b1, 1'b1, 10);
      rd_const(5'h04, "dis_hits", 32'd4);
      rd_const(5'h08, "dis_misses", 32'd0);
      wr(5'h00, 32'h3, 1'b1);
      rd_const(5'h04, "clr_hits", 32'd0);
      rd_const(5'h00, "clr_ctrl", 32'h1);

      // Reset asserted together with an access request: no ready, everything back to reset values
      pulse(1'b1, 1'b1, 3);
      @(negedge clk);
      select = 1'b1; wstrb = 4'd0; addr = 5'h04; reset_n = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (ready) seen = 1'b1;
      end
      select = 1'b0; reset_n = 1'b1;
      check("abort_no_ready", 32'(seen), 32'd0);
      check("abort_data_o", data_o, 32'd0);
      rd_const(5'h00, "abort_ctrl", 32'h1);
      rd_const(5'h04, "abort_hits", 32'd0);
      rd_const(5'h08, "abort_misses", 32'd0);

      // Randomized traffic against the model
      rnd_on = 1'b1;
      for (int n = 0; n < 400; n++) begin
         int op;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         op = $urandom_range(0, 19);
         if (op < 16) begin
            bus(4'd0, 5'($urandom_range(0, 31)), 32'd0, 1'b0, rd, exp);
            check("rand_read", rd, exp);
         end else if (op < 19) begin
            bus(4'($urandom_range(1, 15)), 5'($urandom_range(0, 3)),
                {$urandom_range(0, 65535), 14'd0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)},
                1'b0, rd, exp);
         end else begin
            bus(4'($urandom_range(1, 15)), 5'($urandom_range(4, 31)), $urandom, 1'b0, rd, exp);
         end
      end
      rnd_on = 1'b0;
      @(negedge clk); hit_i = 1'b0; miss_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus(4'd0, 5'(i * 4), 32'd0, 1'b0, rd, exp);
         check("final_read", rd, exp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
